// File: rtl/display_pkg.sv
// display_pkg: shared constants for seven-segment display drivers
package display_pkg;

    localparam int DIGITS = 8;

    // Bit positions inside an 8-bit segment code {dp,g,f,e,d,c,b,a}, active-low
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_0     = 8'hC0;
    localparam seg_t SEG_1     = 8'hF9;
    localparam seg_t SEG_2     = 8'hA4;
    localparam seg_t SEG_3     = 8'hB0;
    localparam seg_t SEG_4     = 8'h99;
    localparam seg_t SEG_5     = 8'h92;
    localparam seg_t SEG_6     = 8'h82;
    localparam seg_t SEG_7     = 8'hF8;
    localparam seg_t SEG_8     = 8'h80;
    localparam seg_t SEG_9     = 8'h90;
    localparam seg_t SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low segments {g..a}, non-decimal values blank
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Look up the glyph; 10-15 have no glyph and render dark
    always_comb begin
        case (value)
            4'd0:    seg = SEG_0[6:0];
            4'd1:    seg = SEG_1[6:0];
            4'd2:    seg = SEG_2[6:0];
            4'd3:    seg = SEG_3[6:0];
            4'd4:    seg = SEG_4[6:0];
            4'd5:    seg = SEG_5[6:0];
            4'd6:    seg = SEG_6[6:0];
            4'd7:    seg = SEG_7[6:0];
            4'd8:    seg = SEG_8[6:0];
            4'd9:    seg = SEG_9[6:0];
            default: seg = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/date_scan_display.sv
// date_scan_display: multiplexes a packed "20YYMMDD" word onto an 8-digit common-anode display
module date_scan_display
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 2,
    parameter int BLINK_DIV = 250
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] Data,
    input  logic [7:0]  blink_mask,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  Sel,
    output logic [7:0]  Seg
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_DIV + 1);
    localparam int IW = $clog2(DIGITS);

    logic [CW-1:0]       slot;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       ridx;
    logic [FW-1:0]       frame;
    logic                phase;
    logic                first;
    logic [4*DIGITS-1:0] snap;
    logic [4*DIGITS-1:0] cur;
    logic [3:0]          nib;
    logic [6:0]          seg7;
    logic                slot_wrap;
    logic                frame_wrap;
    logic                blink_wrap;
    logic                guard;
    logic                blank;

    assign slot_wrap  = slot == CW'(SCAN_DIV - 1);
    assign frame_wrap = slot_wrap && idx == IW'(DIGITS - 1);
    assign blink_wrap = frame == FW'(BLINK_DIV - 1);
    assign guard      = int'(slot) < GUARD;
    // The first cycle after reset shows Data directly, since the snapshot is only being loaded then
    assign cur        = first ? Data : snap;
    assign ridx       = IW'(DIGITS - 1) - idx;
    assign nib        = cur[{ridx, 2'b00} +: 4];
    assign blank      = phase && blink_mask[idx];

    seg7_decode u_dec (
        .value (nib),
        .seg   (seg7)
    );

    // Slot/digit/frame counters, blink phase and the once-per-frame snapshot
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot  <= '0;
            idx   <= '0;
            frame <= '0;
            phase <= 1'b0;
            first <= 1'b1;
            snap  <= '0;
        end else begin
            first <= 1'b0;
            slot  <= slot_wrap ? '0 : slot + 1'b1;
            if (slot_wrap)
                idx <= idx + 1'b1;
            if (first || frame_wrap)
                snap <= Data;
            if (frame_wrap) begin
                frame <= blink_wrap ? '0 : frame + 1'b1;
                if (blink_wrap)
                    phase <= ~phase;
            end
        end
    end

    // Registered digit enable and segment drive, dark during the guard window
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Sel <= 8'hFF;
            Seg <= SEG_BLANK;
        end else begin
            Sel <= guard ? 8'hFF : ~(8'h01 << idx);
            Seg <= (guard || blank) ? SEG_BLANK : {~dp_mask[idx], seg7};
        end
    end

endmodule

// File: tb/tb_date_scan_display.sv
// tb_date_scan_display: vector table, hand sequences and randomized runs against a frame-level model
module tb_date_scan_display;

    localparam int SCAN = 4;
    localparam int GRD  = 1;
    localparam int BD   = 2;
    localparam int FL   = 8 * SCAN;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] Data = '0;
    logic [7:0]  blink_mask = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  Sel;
    logic [7:0]  Seg;

    int total = 0;
    int bad = 0;
    int c = 0;
    logic [31:0] fw [0:255];
    logic [7:0]  dec [0:15];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  blink;
        logic [7:0]  dp;
        int          pos;
        logic [7:0]  seg;
    } vec_t;

    vec_t tbl [0:14];

    date_scan_display #(.SCAN_DIV(SCAN), .GUARD(GRD), .BLINK_DIV(BD)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Data       (Data),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .Sel        (Sel),
        .Seg        (Seg)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at c=%0d: got %h expected %h", name, c, got, exp);
        end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        @(negedge Clk);
        check("reset_sel", Sel, 8'hFF);
        check("reset_seg", Seg, 8'hFF);
        @(negedge Clk);
        Reset_n = 1'b1;
        c = 0;
    endtask

    // One clock: predict the outputs for the state that this edge registers, then compare
    task automatic step();
        int s, p, f, ph;
        logic [31:0] w;
        logic [3:0] d;
        logic [7:0] es, eg;
        if (c == 0) fw[0] = Data;
        if (c % FL == FL - 1) fw[c / FL + 1] = Data;
        s  = c % SCAN;
        p  = (c / SCAN) % 8;
        f  = c / FL;
        ph = (f / BD) % 2;
        w  = fw[f];
        d  = w[4 * (7 - p) +: 4];
        if (s < GRD) begin
            es = 8'hFF;
            eg = 8'hFF;
        end else begin
            es = ~(8'h01 << p);
            eg = (ph == 1 && blink_mask[p]) ? 8'hFF : {~dp_mask[p], dec[d][6:0]};
        end
        @(posedge Clk);
        #1;
        check("model_sel", Sel, es);
        check("model_seg", Seg, eg);
        c++;
    endtask

    initial begin
        logic [31:0] word_a, word_b;
        dec = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        word_a = 32'h1030_5202;
        word_b = 32'h9876_5437;
        tbl[0]  = '{word_a, 8'h00, 8'h00, 7, 8'hA4};
        tbl[1]  = '{word_a, 8'h00, 8'h00, 6, 8'hC0};
        tbl[2]  = '{word_a, 8'h00, 8'h00, 5, 8'hA4};
        tbl[3]  = '{word_a, 8'h00, 8'h00, 4, 8'h92};
        tbl[4]  = '{word_a, 8'h00, 8'h00, 3, 8'hC0};
        tbl[5]  = '{word_a, 8'h00, 8'h00, 2, 8'hB0};
        tbl[6]  = '{word_a, 8'h00, 8'h00, 1, 8'hC0};
        tbl[7]  = '{word_a, 8'h00, 8'h00, 0, 8'hF9};
        tbl[8]  = '{word_a, 8'h00, 8'h54, 6, 8'h40};
        tbl[9]  = '{word_a, 8'h00, 8'h54, 4, 8'h12};
        tbl[10] = '{word_a, 8'h00, 8'h54, 2, 8'h30};
        tbl[11] = '{word_a, 8'h00, 8'h54, 3, 8'hC0};
        tbl[12] = '{32'hB000_0000, 8'h00, 8'h00, 0, 8'hFF};
        tbl[13] = '{32'hB000_0000, 8'h00, 8'h01, 0, 8'h7F};
        tbl[14] = '{32'hF000_0000, 8'hFF, 8'hFF, 0, 8'h7F};

        // Static digit table: each entry shown in frame 0, first visible cycle checked after its guard cycle
        for (int i = 0; i < 15; i++) begin
            Data = tbl[i].data;
            blink_mask = tbl[i].blink;
            dp_mask = tbl[i].dp;
            do_reset();
            for (int k = 0; k < 4 * tbl[i].pos + 1; k++) step();
            check("tbl_guard_sel", Sel, 8'hFF);
            step();
            check("tbl_sel", Sel, ~(8'h01 << tbl[i].pos));
            check("tbl_seg", Seg, tbl[i].seg);
        end

        // Asynchronous reset in the middle of a slot, then restart at position 0
        Data = word_a;
        blink_mask = '0;
        dp_mask = '0;
        do_reset();
        for (int k = 0; k < 7; k++) step();
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_sel", Sel, 8'hFF);
        check("async_seg", Seg, 8'hFF);
        @(negedge Clk);
        Reset_n = 1'b1;
        c = 0;
        step();
        step();
        check("restart_sel", Sel, 8'hFE);

        // Data changes partway through a frame; the old word finishes that frame
        do_reset();
        for (int k = 0; k < 2 * FL; k++) begin
            if (c == 13) Data = word_b;
            step();
            if (c == 22) check("old_word", Seg, 8'hA4);
            if (c == 34) check("new_word", Seg, 8'h90);
            if (c == 62) check("new_pos7", Seg, 8'hF8);
        end

        // Blink on positions 1 and 0: two frames lit, two frames dark
        Data = word_a;
        blink_mask = 8'h03;
        do_reset();
        for (int k = 0; k < 4 * FL + 4; k++) begin
            step();
            if (c == 2)   check("blink_vis0", Seg, 8'hF9);
            if (c == 66)  check("blink_off0", Seg, 8'hFF);
            if (c == 70)  check("blink_off1", Seg, 8'hFF);
            if (c == 74)  check("blink_pos2", Seg, 8'hB0);
            if (c == 98)  check("blink_off0b", Seg, 8'hFF);
            if (c == 130) check("blink_back", Seg, 8'hF9);
        end

        // Randomized words and masks, with Data and masks changing at random cycles
        for (int r = 0; r < 3; r++) begin
            Data = $urandom;
            blink_mask = 8'($urandom);
            dp_mask = 8'($urandom);
            do_reset();
            for (int k = 0; k < 5 * FL; k++) begin
                if ($urandom_range(0, 15) == 0) Data = $urandom;
                if ($urandom_range(0, 31) == 0) blink_mask = 8'($urandom);
                if ($urandom_range(0, 31) == 0) dp_mask = 8'($urandom);
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
